updi_txn_ctrl: RTL and testbench
================================

# updi_txn_ctrl

Transaction sequencer for the UPDI physical layer. It accepts one command at a time: optional double break, then SYNC (0x55), N instruction bytes and M response bytes. It drives the PHY's TX FIFO, double-break and RX FIFO ports. It checks each echoed byte on the single-wire line, forwards response bytes, and bounds every wait with a timeout.

## Interface
- `TIMEOUT_CLK`, default 100000: clk cycles allowed for any single echo or response byte before abort.
- `clk  in  1`: system clock, same domain as the PHY FIFO ports.
- `rst  in  1`: asynchronous, active-low reset.
- `cmd_valid  in  1` / `cmd_ready  out  1`: command handshake.
- `cmd_break  in  1`: issue a double break before SYNC.
- `cmd_tx_len  in  4`: instruction bytes after SYNC, 0–15.
- `cmd_rx_len  in  4`: response bytes expected, 0–15.
- `tx_byte  in  8` / `tx_byte_valid  in  1` / `tx_byte_ready  out  1`: instruction byte stream.
- `rx_byte  out  8` / `rx_byte_valid  out  1`: response byte, 1-cycle pulse, no backpressure.
- `done  out  1`: 1-cycle pulse at end of a command.
- `err  out  2`: result code, valid with `done` and held until the next accept. 0 = ok, 1 = echo mismatch, 2 = timeout, 3 = PHY rx_error.
- `busy  out  1`: high whenever state is not IDLE.
- `phy_tx_data  out  8` / `phy_tx_wr_en  out  1` / `phy_tx_full  in  1`: PHY TX FIFO.
- `phy_rx_data  in  8` / `phy_rx_rd_en  out  1` / `phy_rx_empty  in  1` / `phy_rx_error  in  1`: PHY RX FIFO. Show-ahead: data is valid while not empty, and `rd_en` pops it in the same cycle.
- `phy_db_start  out  1` / `phy_db_busy  in  1` / `phy_db_done  in  1`: double-break engine.

## Operation
- States: IDLE, BREAK, BREAK_WAIT, SEND, ECHO, RECV, FINISH.
- **IDLE**
  - Pops any stale RX byte every cycle.
  - `cmd_ready = phy_rx_empty && !phy_db_busy`.
  - On accept, latches both lengths, clears `err`, and goes to BREAK if `cmd_break`, else SEND with SYNC pending.
- **BREAK**: `phy_db_start` = 1 for one cycle, then BREAK_WAIT.
- **BREAK_WAIT**: wait for `phy_db_done`, then SEND with SYNC pending. Not timed; the double-break engine is self-terminating.
- **SEND**
  - The first byte is SYNC 0x55, generated internally. Following bytes come from the stream.
  - A byte is written when `!phy_tx_full`, and for stream bytes also `tx_byte_valid`.
  - `tx_byte_ready = (state==SEND) && !sync_pending && !phy_tx_full`.
  - The written byte is stored in `expect_reg` and the state goes to ECHO. Transmission is stop-and-wait: one byte outstanding.
- **ECHO**
  - On `!phy_rx_empty`: pop, then compare the popped byte with `expect_reg`.
  - Mismatch → err 1 → FINISH.
  - On match, go to SEND if instruction bytes remain. Otherwise go to RECV if `rx_len` > 0, else FINISH.
- **RECV**
  - Each pop drives `rx_byte`/`rx_byte_valid` on the next cycle, registered.
  - After `rx_len` pops → FINISH.
- **Timeout**: the counter resets on entry to ECHO/RECV and on every pop. It reaches `TIMEOUT_CLK` → err 2 → FINISH.
- **PHY error**: `phy_rx_error` sampled high in ECHO/RECV → err 3 → FINISH. Error priority is 3 > 1 > 2.
- **FINISH**: `done` = 1 for one cycle → IDLE.
- **Aborts**: on abort, unsent stream bytes are not consumed. The requester discards them.
- **Zero lengths**: `cmd_tx_len` = 0 sends SYNC only. `cmd_rx_len` = 0 skips RECV.

## Timing
- Reset values: all outputs 0, `err` = 0, state IDLE, counters 0. Reset mid-command aborts immediately with no `done`.
- Accept → first `phy_tx_wr_en`: 1 cycle without break. With break, the first write follows 1 cycle after `phy_db_done`.
- Write → ECHO entry: same edge. Echo pop → next write: 1 cycle minimum.
- Last pop → `done`: 2 cycles. `rx_byte_valid` for the final byte appears 1 cycle before `done`.
- `phy_tx_wr_en` and `phy_rx_rd_en` are never asserted while full/empty respectively.
- The timeout counter width is `$clog2(TIMEOUT_CLK+1)`. It saturates and never wraps.
- `cmd_valid` while busy is ignored; `cmd_ready` = 0.

## Configuration
- `UPDI_ECHO_CHECK_EN` defined: echo bytes are compared and a mismatch raises err 1.
- Undefined: echo bytes are popped and discarded without comparison. `expect_reg` and the comparator are removed, and err 1 is never produced.
- Timeout and rx_error handling are identical in both builds.

## Test plan
- **LDCS, no break**: cmd(tx_len=1, rx_len=1), tx_byte 0x80, model echoes 0x55, 0x80 then returns 0x30. Required:
  - PHY writes 0x55, 0x80.
  - One `rx_byte` = 0x30.
  - `done` with err 0.
- **Break then STCS**: cmd_break=1, tx_len=2 {0xC3, 0x08}, rx_len=0. Required:
  - `phy_db_start` pulse.
  - No write before `phy_db_done`.
  - Then 0x55, 0xC3, 0x08; err 0.
- **Echo corruption**: model echoes 0x81 for 0x80. Required with the macro: err 1, no RECV, `tx_byte_ready` stays 0 afterward. Without the macro: err 0.
- **Timeout**: `TIMEOUT_CLK`=50, rx_len=2, model returns 1 byte then stays silent. Required: one `rx_byte`, then `done` with err 2 exactly 50 cycles after the pop.
- **rx_error during RECV**: err 3.
- **Stale bytes**: 3 stale RX bytes before the command. Required: all drained in IDLE and `cmd_ready` low until empty.
- **Reset mid-SEND**: async `rst` low mid-SEND. Required: outputs 0 immediately, no `done`, next command runs normally.

Source files
------------

// File: rtl/updi_txn_ctrl_if.sv
// Requester-side bundle for updi_txn_ctrl: command handshake, instruction
// byte stream, response bytes and completion status.
interface updi_txn_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_break;
    logic [3:0] cmd_tx_len;
    logic [3:0] cmd_rx_len;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       done;
    logic [1:0] err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_break, cmd_tx_len, cmd_rx_len, tx_byte, tx_byte_valid,
        input  cmd_ready, tx_byte_ready, rx_byte, rx_byte_valid, done, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_break, cmd_tx_len, cmd_rx_len, tx_byte, tx_byte_valid,
        output cmd_ready, tx_byte_ready, rx_byte, rx_byte_valid, done, err, busy
    );
endinterface

// File: rtl/updi_txn_ctrl.sv
// UPDI transaction sequencer: optional double break, SYNC, stop-and-wait
// instruction bytes with echo check, response capture, per-byte timeout.
// Define UPDI_ECHO_CHECK_EN to compare echoed bytes against what was sent.
module updi_txn_ctrl #(
    parameter int unsigned TIMEOUT_CLK = 100000
) (
    input  logic              clk,
    input  logic              rst,
    updi_txn_ctrl_if.slave    host,
    output logic [7:0]        phy_tx_data,
    output logic              phy_tx_wr_en,
    input  logic              phy_tx_full,
    input  logic [7:0]        phy_rx_data,
    output logic              phy_rx_rd_en,
    input  logic              phy_rx_empty,
    input  logic              phy_rx_error,
    output logic              phy_db_start,
    input  logic              phy_db_busy,
    input  logic              phy_db_done
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLK + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_BREAK      = 3'd1;
    localparam logic [2:0] S_BREAK_WAIT = 3'd2;
    localparam logic [2:0] S_SEND       = 3'd3;
    localparam logic [2:0] S_ECHO       = 3'd4;
    localparam logic [2:0] S_RECV       = 3'd5;
    localparam logic [2:0] S_FINISH     = 3'd6;

    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CLK);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLK - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(2);

    logic [2:0]    state;
    logic          sync_pending;
    logic [3:0]    tx_left;
    logic [3:0]    rx_left;
    logic [1:0]    err_r;
    logic          done_r;
    logic [7:0]    rx_byte_r;
    logic          rx_valid_r;
    logic [TW-1:0] tcnt;
    logic          in_wait;
    logic          tmo_hit;
    logic          echo_bad;
    logic [7:0]    send_byte;

`ifdef UPDI_ECHO_CHECK_EN
    logic [7:0]    expect_reg;
    assign echo_bad = (phy_rx_data != expect_reg);
`else
    assign echo_bad = 1'b0;
`endif

    assign in_wait   = (state == S_ECHO) || (state == S_RECV);
    // Counter is preloaded with the FINISH/done latency so done lands
    // exactly TIMEOUT_CLK cycles after the last pop or write.
    assign tmo_hit   = (tcnt >= T_LAST);
    assign send_byte = sync_pending ? 8'h55 : host.tx_byte;

    assign phy_tx_wr_en  = (state == S_SEND) && !phy_tx_full && (sync_pending || host.tx_byte_valid);
    assign phy_tx_data   = phy_tx_wr_en ? send_byte : '0;
    assign phy_rx_rd_en  = rst && !phy_rx_empty &&
                           ((state == S_IDLE) || (in_wait && !phy_rx_error));
    assign phy_db_start  = (state == S_BREAK);

    assign host.cmd_ready     = rst && (state == S_IDLE) && phy_rx_empty && !phy_db_busy;
    assign host.tx_byte_ready = (state == S_SEND) && !sync_pending && !phy_tx_full;
    assign host.rx_byte       = rx_byte_r;
    assign host.rx_byte_valid = rx_valid_r;
    assign host.done          = done_r;
    assign host.err           = err_r;
    assign host.busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            sync_pending <= 1'b0;
            tx_left      <= '0;
            rx_left      <= '0;
            err_r        <= '0;
            done_r       <= 1'b0;
            rx_byte_r    <= '0;
            rx_valid_r   <= 1'b0;
            tcnt         <= '0;
`ifdef UPDI_ECHO_CHECK_EN
            expect_reg   <= '0;
`endif
        end else begin
            done_r     <= 1'b0;
            rx_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.cmd_valid && host.cmd_ready) begin
                        tx_left      <= host.cmd_tx_len;
                        rx_left      <= host.cmd_rx_len;
                        err_r        <= '0;
                        sync_pending <= 1'b1;
                        state        <= host.cmd_break ? S_BREAK : S_SEND;
                    end
                end
                S_BREAK: state <= S_BREAK_WAIT;
                S_BREAK_WAIT: begin
                    if (phy_db_done) state <= S_SEND;
                end
                S_SEND: begin
                    if (phy_tx_wr_en) begin
`ifdef UPDI_ECHO_CHECK_EN
                        expect_reg <= send_byte;
`endif
                        if (sync_pending) sync_pending <= 1'b0;
                        else              tx_left      <= tx_left - 4'd1;
                        tcnt  <= T_LOAD;
                        state <= S_ECHO;
                    end
                end
                S_ECHO: begin
                    if (phy_rx_error) begin
                        err_r <= 2'd3;
                        state <= S_FINISH;
                    end else if (!phy_rx_empty) begin
                        tcnt <= T_LOAD;
                        if (echo_bad) begin
                            err_r <= 2'd1;
                            state <= S_FINISH;
                        end else if (tx_left != 4'd0) begin
                            state <= S_SEND;
                        end else if (rx_left != 4'd0) begin
                            state <= S_RECV;
                        end else begin
                            state <= S_FINISH;
                        end
                    end else if (tmo_hit) begin
                        err_r <= 2'd2;
                        state <= S_FINISH;
                    end else if (tcnt != T_MAX) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_RECV: begin
                    if (phy_rx_error) begin
                        err_r <= 2'd3;
                        state <= S_FINISH;
                    end else if (!phy_rx_empty) begin
                        tcnt       <= T_LOAD;
                        rx_byte_r  <= phy_rx_data;
                        rx_valid_r <= 1'b1;
                        rx_left    <= rx_left - 4'd1;
                        if (rx_left == 4'd1) state <= S_FINISH;
                    end else if (tmo_hit) begin
                        err_r <= 2'd2;
                        state <= S_FINISH;
                    end else if (tcnt != T_MAX) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_FINISH: begin
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updi_txn_ctrl.sv
// Scoreboard bench for updi_txn_ctrl: a PHY model echoes written bytes and
// returns responses; expectations come from the command-level rules.
module tb_updi_txn_ctrl;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] phy_tx_data;
    logic       phy_tx_wr_en;
    logic       phy_tx_full;
    logic [7:0] phy_rx_data;
    logic       phy_rx_rd_en;
    logic       phy_rx_empty;
    logic       phy_rx_error;
    logic       phy_db_start;
    logic       phy_db_busy;
    logic       phy_db_done;

    updi_txn_ctrl_if h();

    updi_txn_ctrl #(.TIMEOUT_CLK(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (h),
        .phy_tx_data  (phy_tx_data),
        .phy_tx_wr_en (phy_tx_wr_en),
        .phy_tx_full  (phy_tx_full),
        .phy_rx_data  (phy_rx_data),
        .phy_rx_rd_en (phy_rx_rd_en),
        .phy_rx_empty (phy_rx_empty),
        .phy_rx_error (phy_rx_error),
        .phy_db_start (phy_db_start),
        .phy_db_busy  (phy_db_busy),
        .phy_db_done  (phy_db_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] err;
        int         brk;
        bit         tmo;
    } done_t;

    int total = 0;
    int bad   = 0;

    // scoreboard
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    done_t      exp_done[$];

    // PHY / requester model state
    logic [7:0] rxq[$];
    logic [7:0] echo_pend[$];
    logic [7:0] resp[$];
    logic [7:0] streamq[$];
    int  writes_seen = 0, echoes_rel = 0, n_echo_total = 0, corrupt_idx = -1, db_cnt = 0;
    bit  err_inject = 1'b0, force_full = 1'b0;
    logic [7:0] cmd_tx_bytes [16];
    logic [7:0] cmd_rx_bytes [16];

    // monitor state
    int cyc = 0, last_pop = 0, db_pulses = 0;
    bit db_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {phy_tx_wr_en, phy_rx_rd_en, phy_db_start, h.cmd_ready, h.tx_byte_ready,
                   h.rx_byte_valid, h.done, h.busy, h.err, h.rx_byte, phy_tx_data}, 32'd0);
    endtask

    // PHY model: decisions seen mid-cycle are applied just after the edge
    initial begin : phy_model
        bit do_pop, do_wr, do_take, dbs;
        logic [7:0] wdata;
        phy_tx_full = 1'b0; phy_rx_empty = 1'b1; phy_rx_data = '0; phy_rx_error = 1'b0;
        phy_db_busy = 1'b0; phy_db_done = 1'b0; h.tx_byte = '0; h.tx_byte_valid = 1'b0;
        forever begin
            @(negedge clk);
            do_pop  = phy_rx_rd_en;
            do_wr   = phy_tx_wr_en;
            wdata   = phy_tx_data;
            do_take = h.tx_byte_valid && h.tx_byte_ready;
            dbs     = phy_db_start;
            @(posedge clk); #1;
            if (do_pop && rxq.size() != 0) void'(rxq.pop_front());
            if (do_take && streamq.size() != 0) void'(streamq.pop_front());
            if (do_wr) begin
                echo_pend.push_back((writes_seen == corrupt_idx) ? (wdata ^ 8'h01) : wdata);
                writes_seen++;
            end
            if (echo_pend.size() != 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    rxq.push_back(echo_pend.pop_front());
                    echoes_rel++;
                end
            end else if (echoes_rel >= n_echo_total && resp.size() != 0 && $urandom_range(0, 2) != 0) begin
                rxq.push_back(resp.pop_front());
            end
            if (err_inject && resp.size() == 0 && echo_pend.size() == 0 &&
                echoes_rel >= n_echo_total && rxq.size() == 0)
                phy_rx_error = 1'b1;
            phy_db_done = 1'b0;
            if (dbs) begin
                db_cnt = $urandom_range(3, 8);
                phy_db_busy = 1'b1;
            end else if (db_cnt > 0) begin
                db_cnt--;
                if (db_cnt == 0) begin
                    phy_db_done = 1'b1;
                    phy_db_busy = 1'b0;
                end
            end
            phy_tx_full     = force_full || ($urandom_range(0, 3) == 0);
            phy_rx_empty    = (rxq.size() == 0);
            phy_rx_data     = phy_rx_empty ? 8'h00 : rxq[0];
            h.tx_byte_valid = (streamq.size() != 0) && ($urandom_range(0, 3) != 0);
            h.tx_byte       = (streamq.size() != 0) ? streamq[0] : 8'h00;
        end
    end

    // Monitor: pops and compares whenever the DUT presents an output
    initial begin : monitor
        done_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (phy_tx_wr_en) begin
                    if (exp_tx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tx_extra act=%02h req=none", phy_tx_data);
                    end else begin
                        chk("tx_byte", {24'd0, phy_tx_data}, {24'd0, exp_tx.pop_front()});
                    end
                    chk("tx_not_full", {31'd0, phy_tx_full}, 32'd0);
                    chk("tx_after_db_done", {31'd0, db_pending}, 32'd0);
                end
                if (phy_rx_rd_en) begin
                    chk("rd_not_empty", {31'd0, phy_rx_empty}, 32'd0);
                    last_pop = cyc;
                end
                if (h.rx_byte_valid) begin
                    if (exp_rx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rx_extra act=%02h req=none", h.rx_byte);
                    end else begin
                        chk("rx_byte", {24'd0, h.rx_byte}, {24'd0, exp_rx.pop_front()});
                    end
                end
                if (phy_db_start) begin
                    db_pulses++;
                    db_pending = 1'b1;
                end
                if (phy_db_done) db_pending = 1'b0;
                if (!h.busy && !phy_rx_empty)
                    chk("ready_while_stale", {31'd0, h.cmd_ready}, 32'd0);
                if (h.done) begin
                    if (exp_done.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_extra act=%0d req=none", h.err);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_err", {30'd0, h.err}, {30'd0, d.err});
                        chk("db_pulses", db_pulses, d.brk);
                        chk("leftover_exp", exp_tx.size() + exp_rx.size(), 0);
                        if (d.tmo) chk("tmo_latency", cyc - last_pop, TMO);
                    end
                    db_pulses = 0;
                end
            end
        end
    end

    task automatic issue_cmd(input bit brk, input int txl, input int rxl);
        bit acc;
        h.cmd_break  = brk;
        h.cmd_tx_len = 4'(txl);
        h.cmd_rx_len = 4'(rxl);
        h.cmd_valid  = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (h.cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        h.cmd_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL cmd_accept act=no_ready req=ready");
        end
    endtask

    task automatic run_cmd(input bit brk, input int txl, input int rxl,
                           input int corrupt_at, input int nresp, input bit rxerr);
        int k, n_wr;
        logic [1:0] e;
        bit chk_on, seen;
        done_t d;
`ifdef UPDI_ECHO_CHECK_EN
        chk_on = 1'b1;
`else
        chk_on = 1'b0;
`endif
        @(posedge clk); #1;
        k = (nresp < rxl) ? nresp : rxl;
        if (chk_on && corrupt_at >= 0) begin
            n_wr = corrupt_at + 1;
            e    = 2'd1;
            k    = 0;
        end else begin
            n_wr = txl + 1;
            e    = (k < rxl) ? (rxerr ? 2'd3 : 2'd2) : 2'd0;
        end
        exp_tx.push_back(8'h55);
        for (int i = 0; i < n_wr - 1; i++) exp_tx.push_back(cmd_tx_bytes[i]);
        for (int i = 0; i < k; i++) exp_rx.push_back(cmd_rx_bytes[i]);
        d.err = e; d.brk = brk; d.tmo = (e == 2'd2);
        exp_done.push_back(d);
        streamq.delete();
        for (int i = 0; i < txl; i++) streamq.push_back(cmd_tx_bytes[i]);
        resp.delete();
        for (int i = 0; i < k; i++) resp.push_back(cmd_rx_bytes[i]);
        corrupt_idx  = corrupt_at;
        n_echo_total = n_wr;
        writes_seen  = 0;
        echoes_rel   = 0;
        err_inject   = (e == 2'd3);
        issue_cmd(brk, txl, rxl);
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (h.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_wait act=no_done req=done");
        end
        @(posedge clk); #1;
        streamq.delete();
        err_inject   = 1'b0;
        phy_rx_error = 1'b0;
        if (seen) chk("tx_ready_after_done", {31'd0, h.tx_byte_ready}, 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            cmd_tx_bytes[i] = 8'($urandom);
            cmd_rx_bytes[i] = 8'($urandom);
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int txl, rxl, ca, nr;
        bit rxe, brk, got;
        h.cmd_valid = 1'b0; h.cmd_break = 1'b0; h.cmd_tx_len = '0; h.cmd_rx_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset_outputs");
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // LDCS without break
        cmd_tx_bytes[0] = 8'h80; cmd_rx_bytes[0] = 8'h30;
        run_cmd(1'b0, 1, 1, -1, 1, 1'b0);
        // break then STCS
        cmd_tx_bytes[0] = 8'hC3; cmd_tx_bytes[1] = 8'h08;
        run_cmd(1'b1, 2, 0, -1, 0, 1'b0);
        // corrupted echo of 0x80
        cmd_tx_bytes[0] = 8'h80; cmd_rx_bytes[0] = 8'h30;
        run_cmd(1'b0, 1, 1, 1, 1, 1'b0);
        // timeout after one response
        fill_random();
        run_cmd(1'b0, 1, 2, -1, 1, 1'b0);
        // PHY error during RECV
        run_cmd(1'b0, 2, 3, -1, 1, 1'b1);
        // SYNC-only command
        run_cmd(1'b1, 0, 0, -1, 0, 1'b0);

        // stale RX bytes before a command
        @(posedge clk); #1;
        rxq.push_back(8'hA1); rxq.push_back(8'hA2); rxq.push_back(8'hA3);
        phy_rx_empty = 1'b0; phy_rx_data = 8'hA1;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (phy_rx_empty) begin
                got = 1'b1;
                break;
            end
        end
        chk("stale_drained", {31'd0, got}, 32'd1);
        cmd_tx_bytes[0] = 8'h80; cmd_rx_bytes[0] = 8'h30;
        run_cmd(1'b0, 1, 1, -1, 1, 1'b0);

        // reset in the middle of SEND
        force_full = 1'b1;
        @(posedge clk); #1;
        streamq.delete(); streamq.push_back(8'h11); streamq.push_back(8'h22);
        issue_cmd(1'b0, 2, 1);
        #3;
        chk("busy_before_reset", {31'd0, h.busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk_zero_outputs("mid_send_reset_outputs");
        exp_tx.delete(); exp_rx.delete(); exp_done.delete();
        streamq.delete(); echo_pend.delete(); resp.delete(); rxq.delete();
        db_pulses = 0; db_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        force_full = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        fill_random();
        run_cmd(1'b0, 3, 2, -1, 2, 1'b0);

        // randomized commands
        for (int n = 0; n < 25; n++) begin
            fill_random();
            brk = 1'($urandom_range(0, 1));
            txl = int'($urandom_range(0, 15));
            rxl = int'($urandom_range(0, 15));
            ca  = -1;
            nr  = rxl;
            rxe = 1'b0;
            if ($urandom_range(0, 4) == 0) ca = int'($urandom_range(0, txl));
            if (rxl > 0 && $urandom_range(0, 3) == 0) begin
                nr  = int'($urandom_range(0, rxl - 1));
                rxe = 1'($urandom_range(0, 1));
            end
            run_cmd(brk, txl, rxl, ca, nr, rxe);
        end

        repeat (5) @(posedge clk);
        chk("pending_done", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
